// File: rtl/axo_decode_queue_if.sv
// Fetch-to-execute bundle for the buffered decode stage.
// Slave is the decode queue; master is whoever drives fetch and execute.
interface axo_decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [31:0]      out_inst;
  logic             op_valid;
  logic             op_will_read;
  logic             op_will_write;
  logic             op_uses_alu;
  logic             op_does_flowctl;
  logic             op_is_ecall;
  logic             op_is_ebreak;
  logic             op_32bit;
  logic             op_is_imm;
  logic [XLEN-1:0]  imm;
  logic             rd_we;
  logic             rs1_re;
  logic             rs2_re;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [CNT_W-1:0] cnt_decoded;
  logic [CNT_W-1:0] cnt_illegal;

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_inst,
    output op_valid, op_will_read, op_will_write,
    output op_uses_alu, op_does_flowctl,
    output op_is_ecall, op_is_ebreak, op_32bit,
    output op_is_imm, imm, rd_we, rs1_re, rs2_re,
    output rd, rs1, rs2, cnt_decoded, cnt_illegal
  );

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_inst,
    input  op_valid, op_will_read, op_will_write,
    input  op_uses_alu, op_does_flowctl,
    input  op_is_ecall, op_is_ebreak, op_32bit,
    input  op_is_imm, imm, rd_we, rs1_re, rs2_re,
    input  rd, rs1, rs2, cnt_decoded, cnt_illegal
  );
endinterface

// File: rtl/axo_decode_queue.sv
// Buffered RV32I/RV64I decode stage: FIFO of fetched words,
// head decoded combinationally into a registered output slot.
module axo_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  axo_decode_queue_if.slave bus
);
  localparam int   AW   = $clog2(DEPTH);
  localparam logic IS64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;

  typedef struct packed {
    logic            valid;
    logic            rd_op;
    logic            wr_op;
    logic            alu;
    logic            flow;
    logic            ecall;
    logic            ebreak;
    logic            w32;
    logic            isimm;
    logic            rd_we;
    logic            rs1_re;
    logic            rs2_re;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
  } dec_t;

  logic [31:0]      inst_q [DEPTH];
  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_pc_q;
  logic [31:0]      out_inst_q;
  dec_t             dec_d, dec_q;
  logic [CNT_W-1:0] cnt_dec_q, cnt_ill_q;

  logic        full, push, pop, handoff;
  logic [31:0] hd;
  logic [6:0]  opc;
  logic [31:0] sh;
  logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign push    = bus.in_valid && !full;
  assign pop     = (cnt_q != '0) &&
                   (!out_valid_q || bus.out_ready);
  assign handoff = out_valid_q && bus.out_ready;

  assign hd  = inst_q[rd_ptr_q];
  assign opc = hd[6:0];

  assign i_imm = XLEN'($signed(hd[31:20]));
  assign s_imm = XLEN'($signed({hd[31:25], hd[11:7]}));
  assign b_imm = XLEN'($signed({hd[31], hd[7],
                 hd[30:25], hd[11:8], 1'b0}));
  assign u_imm = XLEN'($signed({hd[31:12], 12'b0}));
  assign j_imm = XLEN'($signed({hd[31], hd[19:12],
                 hd[20], hd[30:21], 1'b0}));

  // RV64 OP-IMM shifts carry a 6-bit shamt; *W shifts keep 5 bits
  always_comb begin
    sh = {27'b0, hd[24:20]};
    if (IS64 && opc == OPC_OPIMM) sh = {26'b0, hd[25:20]};
  end

  always_comb begin
    dec_d = '0;
    unique case (1'b1)
      opc == OPC_LOAD: begin
        {dec_d.valid, dec_d.rd_op, dec_d.isimm} = '1;
        {dec_d.rd_we, dec_d.rs1_re} = '1;
        dec_d.imm = i_imm;
      end
      opc == OPC_STORE: begin
        {dec_d.valid, dec_d.wr_op, dec_d.isimm} = '1;
        {dec_d.rs1_re, dec_d.rs2_re} = '1;
        dec_d.imm = s_imm;
      end
      opc == OPC_OPIMM,
      IS64 && opc == OPC_IMM32: begin
        {dec_d.valid, dec_d.alu, dec_d.isimm} = '1;
        {dec_d.rd_we, dec_d.rs1_re} = '1;
        dec_d.w32 = (opc == OPC_IMM32);
        dec_d.imm = (hd[13:12] == 2'b01) ?
                    XLEN'(sh) : i_imm;
      end
      opc == OPC_OP,
      IS64 && opc == OPC_OP32: begin
        {dec_d.valid, dec_d.alu, dec_d.rd_we} = '1;
        {dec_d.rs1_re, dec_d.rs2_re} = '1;
        dec_d.w32 = (opc == OPC_OP32);
      end
      opc == OPC_LUI: begin
        {dec_d.valid, dec_d.isimm, dec_d.rd_we} = '1;
        dec_d.imm = u_imm;
      end
      opc == OPC_AUIPC: begin
        {dec_d.valid, dec_d.isimm, dec_d.rd_we} = '1;
        dec_d.alu = 1'b1;
        dec_d.imm = u_imm;
      end
      opc == OPC_JAL: begin
        {dec_d.valid, dec_d.flow, dec_d.isimm} = '1;
        dec_d.rd_we = 1'b1;
        dec_d.imm   = j_imm;
      end
      opc == OPC_JALR: begin
        {dec_d.valid, dec_d.flow, dec_d.isimm} = '1;
        {dec_d.rd_we, dec_d.rs1_re} = '1;
        dec_d.imm = i_imm;
      end
      opc == OPC_BRANCH: begin
        {dec_d.valid, dec_d.flow, dec_d.isimm} = '1;
        {dec_d.rs1_re, dec_d.rs2_re} = '1;
        dec_d.imm = b_imm;
      end
      hd == 32'h0000_0073: begin
        {dec_d.valid, dec_d.ecall} = '1;
      end
      hd == 32'h0010_0073: begin
        {dec_d.valid, dec_d.ebreak} = '1;
      end
      default: ;
    endcase
    dec_d.rd  = dec_d.rd_we  ? hd[11:7]  : '0;
    dec_d.rs1 = dec_d.rs1_re ? hd[19:15] : '0;
    dec_d.rs2 = dec_d.rs2_re ? hd[24:20] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      dec_q       <= '0;
      cnt_dec_q   <= '0;
      cnt_ill_q   <= '0;
    end else if (bus.flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) begin
        inst_q[wr_ptr_q] <= bus.in_inst;
        pc_q[wr_ptr_q]   <= bus.in_pc;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        out_pc_q   <= pc_q[rd_ptr_q];
        out_inst_q <= hd;
        dec_q      <= dec_d;
      end
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (pop)          out_valid_q <= 1'b1;
      else if (handoff) out_valid_q <= 1'b0;
      if (handoff) begin
        cnt_dec_q <= cnt_dec_q + 1'b1;
        if (!dec_q.valid) cnt_ill_q <= cnt_ill_q + 1'b1;
      end
    end
  end

  assign bus.in_ready        = !full;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_pc          = out_pc_q;
  assign bus.out_inst        = out_inst_q;
  assign bus.op_valid        = dec_q.valid;
  assign bus.op_will_read    = dec_q.rd_op;
  assign bus.op_will_write   = dec_q.wr_op;
  assign bus.op_uses_alu     = dec_q.alu;
  assign bus.op_does_flowctl = dec_q.flow;
  assign bus.op_is_ecall     = dec_q.ecall;
  assign bus.op_is_ebreak    = dec_q.ebreak;
  assign bus.op_32bit        = dec_q.w32;
  assign bus.op_is_imm       = dec_q.isimm;
  assign bus.imm             = dec_q.imm;
  assign bus.rd_we           = dec_q.rd_we;
  assign bus.rs1_re          = dec_q.rs1_re;
  assign bus.rs2_re          = dec_q.rs2_re;
  assign bus.rd              = dec_q.rd;
  assign bus.rs1             = dec_q.rs1;
  assign bus.rs2             = dec_q.rs2;
  assign bus.cnt_decoded     = cnt_dec_q;
  assign bus.cnt_illegal     = cnt_ill_q;
endmodule
